clk_period_meter: RTL and testbench
===================================

// Module: clk_period_meter
// PURPOSE
//  Measures a slow, asynchronous periodic input (e.g. the divided tick from the clock
//  divider, or an accelerometer interrupt/PWM line) in units of the 50 MHz system clock.
//  It performs the inverse of the divider: frequency in, cycle count out.
//  Reports the period and high time, emits edge strobes, and flags a stalled input.
//  Sits between the input pins/divider and the display or UART logic of the accelerometer design.
// PARAMETERS
//  CNT_W        30          width of the period/high-time counters and outputs
//  SYNC_STAGES  2           synchronizer flops on sig_in (>=2)
//  TIMEOUT      50_000_000  cycles without a rising edge before stall (< 2**CNT_W)
// PORTS
//  clk           in   1      system clock, 50 MHz
//  rst           in   1      asynchronous reset, active-low
//  sig_in        in   1      asynchronous signal under measurement
//  rise_pulse    out  1      1-cycle strobe per synchronized rising edge
//  fall_pulse    out  1      1-cycle strobe per synchronized falling edge
//  period        out  CNT_W  clk cycles between the last two rising edges (held)
//  high_time     out  CNT_W  clk cycles from rise to fall in the last full period (held)
//  period_valid  out  1      1-cycle strobe when period/high_time update
//  timeout       out  1      level: input stalled (no rise within TIMEOUT)
// BEHAVIOUR
//  - Reset (rst=0, async): all flops and outputs cleared to 0; state IDLE.
//  - sig_in passes through a SYNC_STAGES flop chain and a prev register. rise = s & ~prev.
//    fall = ~s & prev. rise_pulse/fall_pulse are registered and assert SYNC_STAGES+1 clk
//    edges after the sig_in transition.
//  - FSM: IDLE -> MEASURE -> STALLED.
//    IDLE: cnt=0. On rise -> MEASURE, cnt<=1, hcnt<=1, no valid.
//    MEASURE: cnt increments every clk. hcnt increments while s=1 and freezes on fall.
//      On rise: period<=cnt, high_time<=hcnt, period_valid=1 (same cycle as rise_pulse),
//      cnt<=1, hcnt<=1. If cnt==TIMEOUT-1 and no rise: -> STALLED, timeout<=1,
//      period/high_time hold their last values.
//    STALLED: counters idle. On rise -> MEASURE, cnt<=1, timeout<=0, no valid
//      (the first edge after a stall only restarts measurement).
//  - Simultaneous rise and cnt==TIMEOUT-1: the rise wins (valid update, no stall).
//  - If no fall occurs within a period, high_time = period.
//  - Minimum measurable period: 2 cycles (after synchronization). Shorter pulses are
//    lost by the synchronizer; this is not an error.
//  - Counters never wrap: TIMEOUT bounds cnt below 2**CNT_W.
//  - Reset mid-measurement discards partial counts; the first rise after reset gives no valid.
// CONFIGURATION
//  PERIOD_AVG_EN defined: period = (sum of the last 4 measured periods) >> 2
//    (CNT_W+2-bit accumulator, truncating). period_valid asserts only once 4 periods are
//    collected since the last IDLE/STALLED entry, then on every rise. high_time stays raw.
//  PERIOD_AVG_EN undefined: period is the raw last period. valid fires from the 2nd rise.
// TESTING
//  1. rst=0 with sig_in toggling -> all outputs 0, no strobes. Release -> still no valid
//     until 2 rises.
//  2. Square wave 20000-cycle period, 10000 high (divider output) -> rise_pulse every
//     20000 cycles. period=20000, high_time=10000, period_valid once per period.
//  3. TIMEOUT=1000, stop toggling -> timeout=1 exactly 1000 cycles after the last rise.
//     Resume -> first rise: timeout=0, no valid. Second rise: valid, correct period.
//  4. 4-cycle period, 1 cycle high (post-sync) -> period=4, high_time=1. 1-cycle glitch
//     is not counted as an edge.
//  5. Assert rst mid-period, release, then 2 rises 300 apart -> single valid, period=300.
//  6. PERIOD_AVG_EN, periods 100,100,100,104 -> first valid after the 4th: period=101.
//     Undefined: valids carry 100,100,100,104.

Source files
------------

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - period / high-time meter for a slow asynchronous input
//
// Measures sig_in in units of clk. Synchronizes the input, emits one-cycle edge
// strobes, reports the cycle count between the last two rising edges (period),
// the high time within that period (high_time), and flags a stalled input (timeout).
//
// Optional feature macro: PERIOD_AVG_EN
//   defined   : period is the truncated mean of the last 4 measured periods;
//               period_valid starts once 4 periods are collected since the last
//               IDLE/STALLED entry. high_time stays raw.
//   undefined : period is the raw last period; period_valid from the 2nd rise on.
//
// Ports:
//   clk          in   1      system clock
//   rst          in   1      asynchronous reset, active-low
//   sig_in       in   1      asynchronous signal under measurement
//   rise_pulse   out  1      one-cycle strobe per synchronized rising edge
//   fall_pulse   out  1      one-cycle strobe per synchronized falling edge
//   period       out  CNT_W  clk cycles between the last two rising edges (held)
//   high_time    out  CNT_W  clk cycles high in the last full period (held)
//   period_valid out  1      one-cycle strobe when period/high_time update
//   timeout      out  1      level: no rising edge within TIMEOUT cycles

module clk_period_meter #(
    parameter int CNT_W       = 30,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALLED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   prev;
    logic                   rise;
    logic                   fall;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       hcnt;
    logic                   start;
    logic                   capture;
    logic                   stall;

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~prev;
    assign fall = ~s & prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A rise always wins over the timeout check in the same cycle.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        capture    = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = MEASURE;
                    start      = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    capture = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_next = STALLED;
                    stall      = 1'b1;
                end
            end
            STALLED: begin
                if (rise) begin
                    state_next = MEASURE;
                    start      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef PERIOD_AVG_EN
    logic [CNT_W-1:0] hist0;
    logic [CNT_W-1:0] hist1;
    logic [CNT_W-1:0] hist2;
    logic [2:0]       nper;
    logic [CNT_W+1:0] psum;

    assign psum = {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2} + {2'b00, cnt};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync         <= '0;
            prev         <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            cnt          <= '0;
            hcnt         <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
`ifdef PERIOD_AVG_EN
            hist0        <= '0;
            hist1        <= '0;
            hist2        <= '0;
            nper         <= '0;
`endif
        end else begin
            sync         <= {sync[SYNC_STAGES-2:0], sig_in};
            prev         <= s;
            rise_pulse   <= rise;
            fall_pulse   <= fall;
            period_valid <= 1'b0;

            // The rise cycle itself is the first counted cycle of the new period.
            if (start || capture) begin
                cnt  <= CNT_W'(1);
                hcnt <= CNT_W'(1);
            end else if (state == MEASURE) begin
                cnt <= cnt + CNT_W'(1);
                if (s) begin
                    hcnt <= hcnt + CNT_W'(1);
                end
            end

            if (start) begin
                timeout <= 1'b0;
            end
            if (stall) begin
                timeout <= 1'b1;
            end

            if (capture) begin
                high_time <= hcnt;
`ifdef PERIOD_AVG_EN
                hist0 <= cnt;
                hist1 <= hist0;
                hist2 <= hist1;
                if (nper != 3'd4) begin
                    nper <= nper + 3'd1;
                end
                // nper counts periods collected before this one.
                if (nper >= 3'd3) begin
                    period       <= psum[CNT_W+1:2];
                    period_valid <= 1'b1;
                end
`else
                period       <= cnt;
                period_valid <= 1'b1;
`endif
            end

`ifdef PERIOD_AVG_EN
            if (stall) begin
                nper <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - directed self-checking bench for clk_period_meter
//
// dut_a (TIMEOUT=1000) covers reset, basic measurement, stall/resume, short
// periods, glitches, mid-period reset and the averaging sequence.
// dut_b (default TIMEOUT) covers the 20000-cycle divider square wave.

module tb_clk_period_meter;

    localparam int CNT_W = 30;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sig_a = 1'b0;
    logic             sig_b = 1'b0;

    logic             rise_pulse_a, fall_pulse_a, period_valid_a, timeout_a;
    logic [CNT_W-1:0] period_a, high_time_a;
    logic             rise_pulse_b, fall_pulse_b, period_valid_b, timeout_b;
    logic [CNT_W-1:0] period_b, high_time_b;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT(1000)) dut_a (
        .clk(clk), .rst(rst), .sig_in(sig_a),
        .rise_pulse(rise_pulse_a), .fall_pulse(fall_pulse_a),
        .period(period_a), .high_time(high_time_a),
        .period_valid(period_valid_a), .timeout(timeout_a)
    );

    clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT(50_000_000)) dut_b (
        .clk(clk), .rst(rst), .sig_in(sig_b),
        .rise_pulse(rise_pulse_b), .fall_pulse(fall_pulse_b),
        .period(period_b), .high_time(high_time_b),
        .period_valid(period_valid_b), .timeout(timeout_b)
    );

    // Strobe monitor, sampled 1 time unit after each rising clock edge.
    int cyc = 0;
    int ra_cnt = 0, fa_cnt = 0, va_cnt = 0, ra_cyc = 0, ra_gap = 0;
    int rb_cnt = 0, fb_cnt = 0, vb_cnt = 0, rb_cyc = 0, rb_gap = 0;
    int va_period = 0, va_high = 0, vb_period = 0, vb_high = 0;
    int va_q[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rise_pulse_a) begin ra_gap = cyc - ra_cyc; ra_cyc = cyc; ra_cnt++; end
        if (fall_pulse_a) fa_cnt++;
        if (period_valid_a) begin
            va_cnt++;
            va_period = int'(period_a);
            va_high   = int'(high_time_a);
            va_q.push_back(int'(period_a));
        end
        if (rise_pulse_b) begin rb_gap = cyc - rb_cyc; rb_cyc = cyc; rb_cnt++; end
        if (fall_pulse_b) fb_cnt++;
        if (period_valid_b) begin
            vb_cnt++;
            vb_period = int'(period_b);
            vb_high   = int'(high_time_b);
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_sig(input bit on_b, input logic v);
        if (on_b) sig_b = v;
        else      sig_a = v;
    endtask

    // n periods of length per, each starting with hi cycles high.
    task automatic square(input bit on_b, input int per, input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            set_sig(on_b, 1'b1);
            tick(hi);
            set_sig(on_b, 1'b0);
            tick(per - hi);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int r0;
        int v0;

        // 1. Reset held while the inputs toggle.
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sig_a = ~sig_a;
            sig_b = ~sig_b;
            tick(1);
        end
        check("rst_period", period_a, 0);
        check("rst_high_time", high_time_a, 0);
        check("rst_timeout", timeout_a, 0);
        check("rst_strobes_a", ra_cnt + fa_cnt + va_cnt, 0);
        check("rst_strobes_b", rb_cnt + fb_cnt + vb_cnt + int'(timeout_b), 0);
        sig_a = 1'b0;
        sig_b = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);

        square(1'b0, 50, 20, 1);
        check("first_rise_pulse", ra_cnt, 1);
        check("first_fall_pulse", fa_cnt, 1);
        check("first_rise_no_valid", va_cnt, 0);
        square(1'b0, 50, 20, 1);
        check("second_rise_valid", va_cnt, 1);
        check("second_rise_period", va_period, 50);
        check("second_rise_high", va_high, 20);
        check("rise_gap_50", ra_gap, 50);

        // 3. Stall: timeout 999 cycles after the last rise strobe (TIMEOUT-1 counts).
        waited = 0;
        while (!timeout_a && waited < 1100) begin
            tick(1);
            waited++;
        end
        check("stall_seen", timeout_a, 1);
        check("stall_latency", cyc - ra_cyc, 999);
        tick(20);
        check("stall_level_held", timeout_a, 1);
        check("stall_period_held", period_a, 50);
        check("stall_high_held", high_time_a, 20);
        check("stall_no_valid", va_cnt, 1);
        square(1'b0, 60, 25, 1);
        check("resume_timeout_clear", timeout_a, 0);
        check("resume_no_valid", va_cnt, 1);
        square(1'b0, 60, 25, 1);
        check("resume_valid", va_cnt, 2);
        check("resume_period", va_period, 60);
        check("resume_high", va_high, 25);

        // 4. Short period and a glitch that never reaches a clock edge.
        square(1'b0, 4, 1, 3);
        check("short_valids", va_cnt, 5);
        check("short_period", va_period, 4);
        check("short_high", va_high, 1);
        check("short_gap", ra_gap, 4);
        r0 = ra_cnt;
        @(negedge clk);
        sig_a = 1'b1;
        #1 sig_a = 1'b0;
        tick(6);
        check("glitch_no_rise", ra_cnt, r0);
        check("glitch_no_valid", va_cnt, 5);

        // 5. Reset in the middle of a period.
        sig_a = 1'b1;
        tick(10);
        rst = 1'b0;
        tick(2);
        check("midrst_period", period_a, 0);
        check("midrst_high", high_time_a, 0);
        sig_a = 1'b0;
        tick(2);
        rst = 1'b1;
        v0 = va_cnt;
        square(1'b0, 300, 100, 2);
        check("midrst_single_valid", va_cnt - v0, 1);
        check("midrst_period_300", va_period, 300);
        check("midrst_high_100", va_high, 100);

        // 6. Periods 100,100,100,104 from a fresh reset.
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
        va_q.delete();
        square(1'b0, 100, 40, 3);
        square(1'b0, 104, 40, 1);
        sig_a = 1'b1;
        tick(6);
        sig_a = 1'b0;
`ifdef PERIOD_AVG_EN
        check("avg_valid_count", va_q.size(), 1);
        if (va_q.size() == 1) check("avg_period", va_q[0], 101);
`else
        check("seq_valid_count", va_q.size(), 4);
        if (va_q.size() == 4) begin
            check("seq_period_0", va_q[0], 100);
            check("seq_period_1", va_q[1], 100);
            check("seq_period_2", va_q[2], 100);
            check("seq_period_3", va_q[3], 104);
        end
`endif

        // 2. Divider square wave: 20000-cycle period, 10000 high.
        square(1'b1, 20000, 10000, 2);
        check("sq_rise_count", rb_cnt, 2);
        check("sq_valid_count", vb_cnt, 1);
        check("sq_period", vb_period, 20000);
        check("sq_high", vb_high, 10000);
        check("sq_rise_gap", rb_gap, 20000);
        sig_b = 1'b1;
        tick(6);
        check("sq_third_rise", rb_cnt, 3);
        check("sq_valid_per_period", vb_cnt, 2);
        check("sq_no_timeout", timeout_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
